// File: rtl/multi_edge_detect.sv
// Multi-channel synchronise / debounce / edge-detect block with sticky per-channel
// event flags and a combined interrupt line.
module multi_edge_detect #(
   parameter int CHANNELS        = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [CHANNELS-1:0]     a_i,
   input  logic [2*CHANNELS-1:0]   mode_i,
   input  logic [CHANNELS-1:0]     clear_i,
   output logic [CHANNELS-1:0]     level_o,
   output logic [CHANNELS-1:0]     rising_edge_o,
   output logic [CHANNELS-1:0]     falling_edge_o,
   output logic [CHANNELS-1:0]     pending_o,
   output logic [CHANNELS-1:0]     overflow_o,
   output logic                    irq_o
);

   // Terminal count: the counter reaching this value while a_sync still differs
   // means the new level has been stable for DEBOUNCE_CYCLES cycles.
   localparam logic [7:0] TERM_CNT = 8'(DEBOUNCE_CYCLES - 1);

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   a_sync;
      logic [7:0]             cnt_q;
      logic                   lvl_q;
      logic                   rise_q;
      logic                   fall_q;
      logic                   pend_q;
      logic                   ovf_q;
      logic                   differ;
      logic                   accept;
      logic                   qual;

      assign a_sync = sync_q[SYNC_STAGES-1];
      assign differ = (a_sync != lvl_q);
      assign accept = differ && (cnt_q == TERM_CNT);
      assign qual   = accept && ((a_sync && mode_i[2*n]) || (!a_sync && mode_i[2*n+1]));

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i[n]};
            rise_q <= accept && a_sync;
            fall_q <= accept && !a_sync;
            if (!differ) begin
               cnt_q <= '0;
            end else if (cnt_q == TERM_CNT) begin
               lvl_q <= a_sync;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 8'd1;
            end
         end
      end

      // A clear coinciding with an event keeps the event but drops any overflow.
      always_ff @(posedge clk) begin
         if (reset) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else if (qual) begin
            pend_q <= 1'b1;
            ovf_q  <= clear_i[n] ? 1'b0 : (ovf_q | pend_q);
         end else if (clear_i[n]) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
         end
      end

      assign level_o[n]        = lvl_q;
      assign rising_edge_o[n]  = rise_q;
      assign falling_edge_o[n] = fall_q;
      assign pending_o[n]      = pend_q;
      assign overflow_o[n]     = ovf_q;
   end

   assign irq_o = |pending_o;

endmodule

// File: tb/tb_multi_edge_detect.sv
// Directed bench for multi_edge_detect (4 channels, 2 sync stages, debounce 4).
module tb_multi_edge_detect;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] a_i;
   logic [7:0] mode_i;
   logic [3:0] clear_i;
   logic [3:0] level_o, rising_edge_o, falling_edge_o, pending_o, overflow_o;
   logic       irq_o;
   int         errors = 0;
   int         checks = 0;

   multi_edge_detect #(.CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clear_i(clear_i),
      .level_o(level_o), .rising_edge_o(rising_edge_o), .falling_edge_o(falling_edge_o),
      .pending_o(pending_o), .overflow_o(overflow_o), .irq_o(irq_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; a_i = '0; mode_i = 8'h55; clear_i = '0;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({level_o, rising_edge_o, falling_edge_o, pending_o, overflow_o, irq_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs got lvl=%b r=%b f=%b p=%b o=%b irq=%b exp all 0",
                  level_o, rising_edge_o, falling_edge_o, pending_o, overflow_o, irq_o);
      end
   endtask

   task automatic test_rise();
      a_i = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (level_o !== 4'b0000 || rising_edge_o !== 4'b0000) begin
            errors++;
            $display("FAIL rise_early edge=%0d got lvl=%b r=%b exp 0000 0000", k, level_o, rising_edge_o);
         end
      end
      tick();
      checks++;
      if (level_o !== 4'b0001 || rising_edge_o !== 4'b0001 || pending_o !== 4'b0001 || irq_o !== 1'b1) begin
         errors++;
         $display("FAIL rise_edge6 got lvl=%b r=%b p=%b irq=%b exp 0001 0001 0001 1",
                  level_o, rising_edge_o, pending_o, irq_o);
      end
      tick();
      checks++;
      if (rising_edge_o !== 4'b0000 || level_o !== 4'b0001) begin
         errors++;
         $display("FAIL rise_pulse_width got r=%b lvl=%b exp 0000 0001", rising_edge_o, level_o);
      end
   endtask

   task automatic test_glitch();
      a_i = 4'b0011;
      tick(); tick(); tick();
      a_i = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (level_o !== 4'b0001 || rising_edge_o !== 4'b0000 || falling_edge_o !== 4'b0000 ||
             pending_o !== 4'b0001) begin
            errors++;
            $display("FAIL glitch_reject cyc=%0d got lvl=%b r=%b f=%b p=%b exp 0001 0000 0000 0001",
                     k, level_o, rising_edge_o, falling_edge_o, pending_o);
         end
      end
   endtask

   task automatic test_fall_only();
      mode_i = 8'h65;
      a_i = 4'b0101;
      repeat (6) tick();
      checks++;
      if (rising_edge_o !== 4'b0100 || level_o !== 4'b0101 || pending_o !== 4'b0001) begin
         errors++;
         $display("FAIL fall_mode_rise got r=%b lvl=%b p=%b exp 0100 0101 0001", rising_edge_o, level_o, pending_o);
      end
      tick();
      a_i = 4'b0001;
      repeat (6) tick();
      checks++;
      if (falling_edge_o !== 4'b0100 || level_o !== 4'b0001 || pending_o !== 4'b0101) begin
         errors++;
         $display("FAIL fall_mode_fall got f=%b lvl=%b p=%b exp 0100 0001 0101", falling_edge_o, level_o, pending_o);
      end
   endtask

   task automatic test_overflow();
      a_i = 4'b0000;
      repeat (6) tick();
      checks++;
      if (falling_edge_o !== 4'b0001 || pending_o !== 4'b0101 || overflow_o !== 4'b0000) begin
         errors++;
         $display("FAIL ovf_nonqual_fall got f=%b p=%b o=%b exp 0001 0101 0000", falling_edge_o, pending_o, overflow_o);
      end
      a_i = 4'b0001;
      repeat (6) tick();
      checks++;
      if (rising_edge_o !== 4'b0001 || pending_o !== 4'b0101 || overflow_o !== 4'b0001) begin
         errors++;
         $display("FAIL ovf_set got r=%b p=%b o=%b exp 0001 0101 0001", rising_edge_o, pending_o, overflow_o);
      end
      clear_i = 4'b0101;
      tick();
      clear_i = 4'b0000;
      checks++;
      if (pending_o !== 4'b0000 || overflow_o !== 4'b0000 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got p=%b o=%b irq=%b exp 0000 0000 0", pending_o, overflow_o, irq_o);
      end
   endtask

   task automatic test_clear_coincident();
      mode_i = 8'h67;
      a_i = 4'b0000;
      repeat (6) tick();
      checks++;
      if (falling_edge_o !== 4'b0001 || pending_o !== 4'b0001 || overflow_o !== 4'b0000) begin
         errors++;
         $display("FAIL coinc_setup got f=%b p=%b o=%b exp 0001 0001 0000", falling_edge_o, pending_o, overflow_o);
      end
      a_i = 4'b0001;
      repeat (5) tick();
      clear_i = 4'b0001;
      tick();
      clear_i = 4'b0000;
      checks++;
      if (rising_edge_o !== 4'b0001 || pending_o !== 4'b0001 || overflow_o !== 4'b0000) begin
         errors++;
         $display("FAIL coinc_clear got r=%b p=%b o=%b exp 0001 0001 0000", rising_edge_o, pending_o, overflow_o);
      end
   endtask

   task automatic test_mode_change();
      mode_i = 8'h64;
      tick();
      checks++;
      if (pending_o !== 4'b0001 || overflow_o !== 4'b0000) begin
         errors++;
         $display("FAIL mode_change_keep got p=%b o=%b exp 0001 0000", pending_o, overflow_o);
      end
      a_i = 4'b0000;
      repeat (6) tick();
      checks++;
      if (falling_edge_o !== 4'b0001 || pending_o !== 4'b0001 || overflow_o !== 4'b0000) begin
         errors++;
         $display("FAIL mode_off_event got f=%b p=%b o=%b exp 0001 0001 0000", falling_edge_o, pending_o, overflow_o);
      end
   endtask

   task automatic test_reset_mid();
      a_i = 4'b1000;
      repeat (4) tick();
      reset = 1'b1;
      clear_i = 4'b0000;
      tick();
      reset = 1'b0;
      checks++;
      if ({level_o, rising_edge_o, falling_edge_o, pending_o, overflow_o, irq_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got lvl=%b r=%b f=%b p=%b o=%b irq=%b exp all 0",
                  level_o, rising_edge_o, falling_edge_o, pending_o, overflow_o, irq_o);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         checks++;
         if (rising_edge_o[3] !== 1'b0 || level_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_early edge=%0d got r3=%b lvl3=%b exp 0 0", k, rising_edge_o[3], level_o[3]);
         end
      end
      tick();
      checks++;
      if (rising_edge_o !== 4'b1000 || level_o !== 4'b1000 || pending_o !== 4'b1000) begin
         errors++;
         $display("FAIL reset_mid_rise got r=%b lvl=%b p=%b exp 1000 1000 1000", rising_edge_o, level_o, pending_o);
      end
   endtask

   task automatic test_simultaneous();
      mode_i = 8'hFF;
      clear_i = 4'b1111;
      tick();
      clear_i = 4'b0000;
      checks++;
      if (pending_o !== 4'b0000 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL simul_clear got p=%b irq=%b exp 0000 0", pending_o, irq_o);
      end
      a_i = 4'b0110;
      repeat (6) tick();
      checks++;
      if (rising_edge_o !== 4'b0110 || falling_edge_o !== 4'b1000 || pending_o !== 4'b1110 ||
          level_o !== 4'b0110) begin
         errors++;
         $display("FAIL simul_events got r=%b f=%b p=%b lvl=%b exp 0110 1000 1110 0110",
                  rising_edge_o, falling_edge_o, pending_o, level_o);
      end
      tick();
      checks++;
      if (rising_edge_o !== 4'b0000 || falling_edge_o !== 4'b0000) begin
         errors++;
         $display("FAIL simul_pulse_end got r=%b f=%b exp 0000 0000", rising_edge_o, falling_edge_o);
      end
   endtask

   initial begin
      test_reset();
      test_rise();
      test_glitch();
      test_fall_only();
      test_overflow();
      test_clear_coincident();
      test_mode_change();
      test_reset_mid();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multi_edge_detect.md
MULTI_EDGE_DETECT -- requirements
Module: multi_edge_detect

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel, 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronised cycles required to accept a new level, 1..255.
REQ-004 clk  input  1  single clock for all logic; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 a_i  input  CHANNELS  asynchronous raw levels, one bit per channel.
REQ-007 mode_i  input  2*CHANNELS  per-channel event select, bits [2n+1:2n]: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 clear_i  input  CHANNELS  per-channel clear for pending_o/overflow_o, sampled each edge.
REQ-009 level_o  output  CHANNELS  debounced accepted level.
REQ-010 rising_edge_o  output  CHANNELS  one-cycle pulse on accepted 0->1.
REQ-011 falling_edge_o  output  CHANNELS  one-cycle pulse on accepted 1->0.
REQ-012 pending_o  output  CHANNELS  sticky flag, qualifying event seen.
REQ-013 overflow_o  output  CHANNELS  sticky flag, qualifying event while pending already set.
REQ-014 irq_o  output  1  OR of all pending_o bits.

Function
REQ-015 Each channel SHALL pass a_i[n] through a SYNC_STAGES-deep flop chain; last stage is a_sync[n].
REQ-016 Each channel SHALL hold a debounce counter of 8 bits and an accepted level register lvl[n] driving level_o[n].
REQ-017 a_sync==lvl: counter SHALL load 0.
REQ-018 a_sync!=lvl and counter<DEBOUNCE_CYCLES-1: counter SHALL increment.
REQ-019 a_sync!=lvl and counter==DEBOUNCE_CYCLES-1: lvl SHALL load a_sync, counter SHALL load 0.
REQ-020 A synchronised excursion shorter than DEBOUNCE_CYCLES cycles SHALL produce no level change and no pulse.
REQ-021 Latency: a_i step stable before edge 1 SHALL appear on level_o after edge SYNC_STAGES+DEBOUNCE_CYCLES.
REQ-022 rising_edge_o/falling_edge_o SHALL be registered, asserted for exactly the one cycle in which level_o first shows the new value, independent of mode_i.
REQ-023 Qualifying event: accepted rise with mode bit0=1, or accepted fall with mode bit1=1; mode 00 SHALL never set pending_o.
REQ-024 Qualifying event SHALL set pending_o[n] at the same edge the edge pulse asserts.
REQ-025 Qualifying event with pending_o[n]=1 and clear_i[n]=0 SHALL set overflow_o[n].
REQ-026 clear_i[n]=1 with no qualifying event SHALL clear pending_o[n] and overflow_o[n] at that edge.
REQ-027 clear_i[n]=1 coincident with qualifying event: pending_o[n] SHALL remain/become 1, overflow_o[n] SHALL become 0 (event not lost).
REQ-028 mode_i changes SHALL take effect at the next edge and SHALL NOT alter existing pending_o/overflow_o.
REQ-029 irq_o SHALL be combinational OR of pending_o registers only.
REQ-030 Channels SHALL be fully independent; simultaneous events on any channel set SHALL all be captured.

Reset
REQ-031 reset=1 at an edge SHALL clear synchroniser flops, counters, lvl, edge pulses, pending_o, overflow_o to 0; irq_o=0 the following cycle.
REQ-032 Reset mid-debounce SHALL discard the count; reset dominates clear_i and events.
REQ-033 a_i held 1 through reset SHALL yield a rising edge SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge with reset=0.

Verification (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-034 Reset, mode_i=8'h55, a_i[0] 0->1 held -> level_o[0]=1, rising_edge_o[0] one-cycle pulse after edge 6, pending_o[0]=1, irq_o=1.
REQ-035 a_i[1] high 3 cycles then low -> level_o, edge pulses, pending_o all stay 0.
REQ-036 mode ch2=10, a_i[2] rise then fall -> rising pulse with no pending; falling pulse sets pending_o[2].
REQ-037 ch0 pending, second qualifying event, clear_i=0 -> overflow_o[0]=1; later clear_i[0] pulse -> pending_o[0]=0, overflow_o[0]=0, irq_o=0.
REQ-038 clear_i[0] on same edge as qualifying event -> pending_o[0]=1, overflow_o[0]=0.
REQ-039 a_i[3]=1 for 4 cycles, reset pulse, a_i held 1 -> all outputs 0 after reset; rising_edge_o[3] at edge 6 after reset release.
